// File: rtl/pipe_pkg.sv
// Shared definitions for the multi-port RX ingress front end:
// arbitration modes, FSM encoding and port-index width helper.
package pipe_pkg;

   localparam int unsigned ARB_RR   = 0;
   localparam int unsigned ARB_PRIO = 1;

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   typedef enum logic {
      StIdle = 1'b0,
      StLock = 1'b1
   } arb_state_e;

   function automatic int unsigned port_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mac_rx_arb_pipe_fifo.sv
// Per-port synchronous FIFO of {last, data} with a saturating counter of
// beats offered while the FIFO was full.
module rx_port_fifo
   import pipe_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_valid,
   input  logic [7:0]  push_data,
   input  logic        push_last,
   output logic        push_ready,
   input  logic        pop,
   output logic [7:0]  head_data,
   output logic        head_last,
   output logic        empty,
   output logic [15:0] drop_cnt
);

   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]       drop_q, drop_d;
   logic [8:0]        mem_q [DEPTH];
   logic              full, push, pop_ok;

   // Ready comes from the registered count only, so a pop never enables a
   // same-cycle push into a full FIFO.
   assign full       = (count_q == (ADDR_W + 1)'(DEPTH));
   assign empty      = (count_q == '0);
   assign push_ready = !full;
   assign push       = push_valid & !full;
   assign pop_ok     = pop & !empty;
   assign head_data  = mem_q[rd_ptr_q][7:0];
   assign head_last  = mem_q[rd_ptr_q][8];
   assign drop_cnt   = drop_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push && !pop_ok) begin
         count_d = count_q + (ADDR_W + 1)'(1);
      end else if (!push && pop_ok) begin
         count_d = count_q - (ADDR_W + 1)'(1);
      end
      if (push_valid && full && (drop_q != DROP_MAX)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {push_last, push_data};
   end

endmodule

// File: rtl/mac_rx_arb_pipe.sv
// Multi-port MAC RX ingress: per-port FIFOs merged packet-atomically into one
// byte stream tagged with the ingress port (round-robin or fixed priority).
module mac_rx_arb_pipe
   import pipe_pkg::*;
#(
   parameter int unsigned NUM_PORTS   = 4,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned FIFO_ADDR_W = 4,
   parameter int unsigned ARB_MODE    = ARB_RR,
   localparam int unsigned PORT_W     = port_w(NUM_PORTS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    mac_rx_valid,
   input  logic [8*NUM_PORTS-1:0]  mac_rx_data,
   input  logic [NUM_PORTS-1:0]    mac_rx_last,
   output logic [NUM_PORTS-1:0]    mac_rx_ready,
   input  logic [NUM_PORTS-1:0]    port_en,
   output logic                    out_valid,
   output logic [7:0]              out_data,
   output logic                    out_last,
   output logic                    out_sop,
   output logic [PORT_W-1:0]       out_port,
   input  logic                    out_ready,
   output logic [16*NUM_PORTS-1:0] drop_cnt
);

   arb_state_e           state_q;
   logic [PORT_W-1:0]    grant_q;
   logic [PORT_W-1:0]    last_grant_q;
   logic                 sop_pend_q;

   logic [7:0]           head_data [NUM_PORTS];
   logic [NUM_PORTS-1:0] head_last;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] cand;
   logic [PORT_W-1:0]    pick;
   logic                 any_cand;
   logic                 locked;
   logic                 pop_fire;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      rx_port_fifo #(
         .DEPTH  (FIFO_DEPTH),
         .ADDR_W (FIFO_ADDR_W)
      ) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .push_valid (mac_rx_valid[p]),
         .push_data  (mac_rx_data[8*p +: 8]),
         .push_last  (mac_rx_last[p]),
         .push_ready (mac_rx_ready[p]),
         .pop        (pop[p]),
         .head_data  (head_data[p]),
         .head_last  (head_last[p]),
         .empty      (empty[p]),
         .drop_cnt   (drop_cnt[16*p +: 16])
      );
   end

   // Descending scans so the highest-priority candidate is written last.
   always_comb begin
      cand     = port_en & ~empty;
      any_cand = |cand;
      pick     = '0;
      if (ARB_MODE == ARB_PRIO) begin
         for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (cand[i]) pick = PORT_W'(i);
         end
      end else begin
         for (int i = int'(NUM_PORTS); i >= 1; i--) begin
            if (cand[(int'(last_grant_q) + i) % int'(NUM_PORTS)]) begin
               pick = PORT_W'((int'(last_grant_q) + i) % int'(NUM_PORTS));
            end
         end
      end
   end

   always_comb begin
      locked    = (state_q == StLock);
      out_valid = locked & ~empty[grant_q];
      out_data  = out_valid ? head_data[grant_q] : 8'h00;
      out_last  = out_valid & head_last[grant_q];
      out_sop   = out_valid & sop_pend_q;
      out_port  = locked ? grant_q : '0;
      pop_fire  = out_valid & out_ready;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         pop[p] = pop_fire && (grant_q == PORT_W'(p));
      end
   end

   // The lock is released only by popping the last byte; port_en and an
   // empty FIFO mid-packet never break it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= PORT_W'(NUM_PORTS - 1);
         sop_pend_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_cand) begin
                  grant_q    <= pick;
                  sop_pend_q <= 1'b1;
                  state_q    <= StLock;
               end
            end
            StLock: begin
               if (pop_fire) begin
                  sop_pend_q <= 1'b0;
                  if (head_last[grant_q]) begin
                     last_grant_q <= grant_q;
                     state_q      <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mac_rx_arb_pipe.md
# mac_rx_arb_pipe

Multi-port ingress front end for the data-plane pipeline: accepts byte streams from NUM_PORTS MAC RX channels, buffers each in its own FIFO, and merges them packet-atomically into one byte stream tagged with the ingress port. It sits between the MAC RX interfaces and the header buffer stage, replacing the single-channel RX FIFO. Arbitration is round-robin or fixed-priority, selected by parameter.

## Interface
- NUM_PORTS, 4, number of MAC RX channels (2..16)
- FIFO_DEPTH, 16, entries per port FIFO (power of two)
- FIFO_ADDR_W, 4, log2(FIFO_DEPTH)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
- PORT_W, derived localparam, max(1, $clog2(NUM_PORTS))

- clk  in  1  single clock
- rst_n  in  1  reset; synchronous, active-low
- mac_rx_valid  in  NUM_PORTS  per-port byte valid
- mac_rx_data  in  8*NUM_PORTS  per-port byte; port p at [8p+7:8p]
- mac_rx_last  in  NUM_PORTS  per-port last byte of packet
- mac_rx_ready  out  NUM_PORTS  per-port FIFO not full
- port_en  in  NUM_PORTS  port may be granted a new packet
- out_valid  out  1  merged byte valid
- out_data  out  8  merged byte
- out_last  out  1  last byte of packet
- out_sop  out  1  first byte of packet
- out_port  out  PORT_W  ingress port of current packet
- out_ready  in  1  downstream accept
- drop_cnt  out  16*NUM_PORTS  per-port count of beats offered while FIFO full, saturating

## Operation
- Per port: FIFO of {last, data}; push on mac_rx_valid & mac_rx_ready; mac_rx_ready = !full (registered count). Push while full is not accepted and increments that port's drop_cnt (saturates at 0xFFFF).
- States: IDLE, LOCK.
- IDLE: candidates = port_en & fifo_nonempty. None -> stay. Else register grant: round-robin picks first candidate after last_grant (wrapping); fixed picks lowest index. Go to LOCK, set sop_pend.
- LOCK: out_valid = !empty[grant]; out_data/out_last = head of grant FIFO; out_port = grant; out_sop = sop_pend. Pop on out_valid & out_ready; clear sop_pend on pop. On pop with out_last = 1: last_grant <= grant, -> IDLE.
- Packet atomicity: no interleave. Locked port going empty mid-packet -> out_valid low, stay in LOCK. Deasserting port_en mid-packet does not break lock.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged; allowed when full (pop frees, push accepted only if ready was high that cycle — ready is from registered count, so no push when full).
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (rst_n low at edge): all FIFOs empty, state IDLE, last_grant = NUM_PORTS-1 (port 0 first), sop_pend 0, drop_cnt 0. Outputs: mac_rx_ready all 1, out_valid 0, out_sop 0, out_last 0, out_data 0, out_port 0. Reset mid-packet discards all buffered data.
- Latency: byte pushed into empty FIFO of idle block -> IDLE decision next cycle -> out_valid earliest 2 cycles after push.
- One IDLE bubble cycle between consecutive packets.
- out_data/out_last/out_port/out_sop held stable while out_valid & !out_ready.
- Throughput: 1 byte/cycle within a packet when FIFO non-empty and out_ready high.
- 1-byte packet (sop and last on same beat) legal; out_sop and out_last both high.

## Structure
- Shared package pipe_pkg: ARB_RR / ARB_PRIO constants, state encoding, function for PORT_W.
- Sub-module rx_port_fifo (one per port via generate): sync FIFO {last,data}, full/empty/count, drop counter.
- Arbiter, state machine and output mux in mac_rx_arb_pipe.

## Test plan
- Single port 0, packet 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_valid 2 cycles after first push; bytes in order; out_sop on 0x11, out_last on 0x33, out_port=0.
- Ports 0..3 each preloaded with 2-byte packet, RR mode -> output order ports 0,1,2,3; one idle cycle between packets; no interleave.
- Same preload, ARB_MODE=1, port 0 refilled each time -> port 0 served repeatedly, port 3 starved while port 0 non-empty.
- Port 1 offers 20 bytes with out_ready=0, depth 16 -> mac_rx_ready[1] low after 16, drop_cnt[1]=4.
- Locked on port 2, its FIFO empties mid-packet while port 3 has data -> out_valid low, port 3 not granted until port 2 last byte popped.
- Reset asserted mid-packet with out_ready toggling -> next cycle out_valid=0, all mac_rx_ready=1, drop_cnt=0; new packet on port 3 output with out_sop=1.
